// File: rtl/uvmt_mio_cli_st_xchg_if.sv
// rtl/uvmt_mio_cli_st_xchg_if.sv - bob/alice handshake bundle plus level and count taps
interface uvmt_mio_cli_st_xchg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                  bob_tx_valid;
    logic                  bob_tx_ready;
    logic [DATA_WIDTH-1:0] bob_tx_data;
    logic                  alice_rx_valid;
    logic                  alice_rx_ready;
    logic [DATA_WIDTH-1:0] alice_rx_data;
    logic                  alice_tx_valid;
    logic                  alice_tx_ready;
    logic [DATA_WIDTH-1:0] alice_tx_data;
    logic                  bob_rx_valid;
    logic                  bob_rx_ready;
    logic [DATA_WIDTH-1:0] bob_rx_data;
    logic [LW-1:0]         b2a_level;
    logic [LW-1:0]         a2b_level;
    logic [CNT_WIDTH-1:0]  b2a_count;
    logic [CNT_WIDTH-1:0]  a2b_count;

    modport slave (
        input  bob_tx_valid, bob_tx_data, alice_rx_ready,
        input  alice_tx_valid, alice_tx_data, bob_rx_ready,
        output bob_tx_ready, alice_rx_valid, alice_rx_data,
        output alice_tx_ready, bob_rx_valid, bob_rx_data,
        output b2a_level, a2b_level, b2a_count, a2b_count
    );

    modport master (
        output bob_tx_valid, bob_tx_data, alice_rx_ready,
        output alice_tx_valid, alice_tx_data, bob_rx_ready,
        input  bob_tx_ready, alice_rx_valid, alice_rx_data,
        input  alice_tx_ready, bob_rx_valid, bob_rx_data,
        input  b2a_level, a2b_level, b2a_count, a2b_count
    );
endinterface

// File: rtl/uvmt_mio_cli_st_xchg.sv
// rtl/uvmt_mio_cli_st_xchg.sv - two independent buffered valid/ready channels between bob and alice
module uvmt_mio_cli_st_xchg_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_WIDTH-1:0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  tx_ready_q, tx_ready_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  push, pop;

    assign rx_valid = (wr_ptr_q != rd_ptr_q);
    assign rx_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign level    = wr_ptr_q - rd_ptr_q;
    assign count    = count_q;
    assign tx_ready = tx_ready_q;

    // Ready is a flop of the next-state fullness, so a pop while full frees a slot one cycle later.
    always_comb begin
        push       = tx_valid && tx_ready_q;
        pop        = rx_valid && rx_ready;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CNT_WIDTH'(pop);
        tx_ready_d = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]));
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_ready_q <= tx_ready_d;
            mem_q      <= mem_d;
        end
    end
endmodule

module uvmt_mio_cli_st_xchg #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic                  clk,
    input logic                  reset_n,
    uvmt_mio_cli_st_xchg_if.slave xif
);
    uvmt_mio_cli_st_xchg_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_b2a (
        .clk      (clk),
        .rst_n    (reset_n),
        .tx_valid (xif.bob_tx_valid),
        .tx_ready (xif.bob_tx_ready),
        .tx_data  (xif.bob_tx_data),
        .rx_valid (xif.alice_rx_valid),
        .rx_ready (xif.alice_rx_ready),
        .rx_data  (xif.alice_rx_data),
        .level    (xif.b2a_level),
        .count    (xif.b2a_count)
    );

    uvmt_mio_cli_st_xchg_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_a2b (
        .clk      (clk),
        .rst_n    (reset_n),
        .tx_valid (xif.alice_tx_valid),
        .tx_ready (xif.alice_tx_ready),
        .tx_data  (xif.alice_tx_data),
        .rx_valid (xif.bob_rx_valid),
        .rx_ready (xif.bob_rx_ready),
        .rx_data  (xif.bob_rx_data),
        .level    (xif.a2b_level),
        .count    (xif.a2b_count)
    );
endmodule
